// File: rtl/handshake_const_sink_check.sv
// Valid/ready channel terminator with a one-entry slot.
// Drained tokens are checked against a fixed constant.
module handshake_const_sink_check #(
    parameter int unsigned               DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]     EXPECTED    = 32'h2E705901,
    parameter int unsigned               COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    input  logic                   drain_en,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] tok_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic                   error,
    output logic [DATA_WIDTH-1:0]  first_err_data
);

    logic                   slot_full_q, slot_full_d;
    logic [DATA_WIDTH-1:0]  slot_data_q, slot_data_d;
    logic [COUNT_WIDTH-1:0] tok_count_q, tok_count_d;
    logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                   error_q, error_d;
    logic [DATA_WIDTH-1:0]  first_err_q, first_err_d;

    logic accept;
    logic drain;
    logic mismatch;

    // Ready looks through a draining slot so back-to-back tokens flow.
    assign ins_ready = ~rst & (~slot_full_q | drain_en);
    assign accept    = ins_valid & ins_ready;
    assign drain     = slot_full_q & drain_en;
    assign mismatch  = slot_data_q != EXPECTED;

    always_comb begin
        slot_full_d = slot_full_q;
        slot_data_d = slot_data_q;
        tok_count_d = tok_count_q;
        err_count_d = err_count_q;
        error_d     = error_q;
        first_err_d = first_err_q;

        if (accept) begin
            slot_full_d = 1'b1;
            slot_data_d = ins;
        end else if (drain) begin
            slot_full_d = 1'b0;
        end

        // A clear swallows any token drained in the same cycle.
        if (clear) begin
            tok_count_d = '0;
            err_count_d = '0;
            error_d     = 1'b0;
            first_err_d = '0;
        end else if (drain) begin
            if (tok_count_q != '1) begin
                tok_count_d = tok_count_q + 1'b1;
            end
            if (mismatch) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + 1'b1;
                end
                if (!error_q) begin
                    error_d     = 1'b1;
                    first_err_d = slot_data_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full_q <= 1'b0;
            slot_data_q <= '0;
            tok_count_q <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
            first_err_q <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            slot_data_q <= slot_data_d;
            tok_count_q <= tok_count_d;
            err_count_q <= err_count_d;
            error_q     <= error_d;
            first_err_q <= first_err_d;
        end
    end

    assign tok_count      = tok_count_q;
    assign err_count      = err_count_q;
    assign error          = error_q;
    assign first_err_data = first_err_q;

endmodule
